// File: rtl/mem_stage_lsu_pkg.sv
// Shared RISC-V LSU definitions: load/store size codes, controller state encoding and
// byte-lane helpers used by the MEM-stage load/store unit.
package riscv_pkg;

    localparam logic [2:0] LOAD_LW  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LB  = 3'b010;
    localparam logic [2:0] LOAD_LHU = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;

    localparam logic [1:0] STORE_SW = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SB = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    // Undefined store codes fall back to a full-word write.
    function automatic logic [3:0] storeByteEn(input logic [1:0] storeSrc, input logic [1:0] offset);
        case (storeSrc)
            STORE_SH: return 4'b0011 << {offset[1], 1'b0};
            STORE_SB: return 4'b0001 << offset;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic isLoad, input logic [2:0] loadSrc,
                                          input logic [1:0] storeSrc, input logic [1:0] offset);
        if (isLoad) begin
            case (loadSrc)
                LOAD_LH, LOAD_LHU: return offset[0];
                LOAD_LB, LOAD_LBU: return 1'b0;
                default:           return offset != 2'b00;
            endcase
        end
        case (storeSrc)
            STORE_SH: return offset[0];
            STORE_SB: return 1'b0;
            default:  return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the MEM-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if #(parameter int unsigned XLEN = 32);

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load alignment: shifts the addressed lane down and sign/zero-extends it.
module lsu_load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      loadSrc,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] lane;

    always_comb begin
        lane = rdata >> {offset, 3'b000};
        case (loadSrc)
            LOAD_LB:  result = {{(XLEN-8){lane[7]}}, lane[7:0]};
            LOAD_LBU: result = {{(XLEN-8){1'b0}}, lane[7:0]};
            LOAD_LH:  result = {{(XLEN-16){lane[15]}}, lane[15:0]};
            LOAD_LHU: result = {{(XLEN-16){1'b0}}, lane[15:0]};
            default:  result = lane;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: byte-enabled req/gnt/rvalid transactions with timeout.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW trap with bus_err instead of issuing.
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             store,
    input  logic [2:0]       load_src,
    input  logic [1:0]       store_src,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  rdata_out,
    output logic             done,
    output logic             stall,
    output logic             bus_err,
    mem_stage_lsu_if.master  bus
);

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

    lsu_state_t       state;
    logic [CW-1:0]    toCnt;
    logic [1:0]       offset;
    logic [2:0]       sizeQ;
    logic [XLEN-1:0]  alignedData;
    logic             isStore;
    logic [XLEN-1:0]  storeData;
    logic             timeoutHit;

    lsu_load_align #(.XLEN(XLEN)) uAlign (
        .rdata   (bus.dmem_rdata),
        .offset  (offset),
        .loadSrc (sizeQ),
        .result  (alignedData)
    );

    assign isStore    = store & ~load;
    assign timeoutHit = (toCnt == TO_LAST);
    assign stall      = ((state == IDLE) && (load || store)) || (state == REQ) || (state == WAIT);

    always_comb begin
        case (store_src)
            STORE_SH: storeData = {(XLEN/16){wdata[15:0]}};
            STORE_SB: storeData = {(XLEN/8){wdata[7:0]}};
            default:  storeData = wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            toCnt          <= '0;
            offset         <= '0;
            sizeQ          <= '0;
            rdata_out      <= '0;
            done           <= 1'b0;
            bus_err        <= 1'b0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_be    <= '0;
            bus.dmem_wdata <= '0;
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load || store) begin
                        offset         <= addr[1:0];
                        sizeQ          <= load_src;
                        toCnt          <= '0;
                        bus.dmem_we    <= isStore;
                        bus.dmem_addr  <= {addr[XLEN-1:2], 2'b00};
                        bus.dmem_be    <= isStore ? storeByteEn(store_src, addr[1:0]) : 4'b1111;
                        bus.dmem_wdata <= storeData;
`ifdef MISALIGN_TRAP_EN
                        if (isMisaligned(load, load_src, store_src, addr[1:0])) begin
                            rdata_out <= '0;
                            bus_err   <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bus.dmem_req <= 1'b1;
                            state        <= REQ;
                        end
`else
                        bus.dmem_req <= 1'b1;
                        state        <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        bus.dmem_req <= 1'b0;
                        toCnt        <= '0;
                        if (bus.dmem_we) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (bus.dmem_rvalid) begin
                            rdata_out <= alignedData;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (timeoutHit) begin
                        bus.dmem_req <= 1'b0;
                        rdata_out    <= '0;
                        bus_err      <= 1'b1;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.dmem_rvalid) begin
                        rdata_out <= alignedData;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (timeoutHit) begin
                        rdata_out <= '0;
                        bus_err   <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus queues expected bus requests and responses,
// a negedge monitor pops and compares them when the DUT presents gnt-accepted requests or done.
module tb_mem_stage_lsu;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chkWdata;
    } reqExp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        chkRdata;
        logic        err;
        int          stallCycles;
    } respExp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [2:0]  load_src = '0;
    logic [1:0]  store_src = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_out;
    logic        done;
    logic        stall;
    logic        bus_err;

    int errors = 0;
    int checks = 0;
    int stallCnt = 0;
    reqExp_t  reqQ[$];
    respExp_t respQ[$];

    mem_stage_lsu_if #(.XLEN(32)) bus ();

    mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYC(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .store     (store),
        .load_src  (load_src),
        .store_src (store_src),
        .addr      (addr),
        .wdata     (wdata),
        .rdata_out (rdata_out),
        .done      (done),
        .stall     (stall),
        .bus_err   (bus_err),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stallCnt = 0;
        end else begin
            if (stall) stallCnt++;
            if (bus.dmem_req && bus.dmem_gnt) begin
                if (reqQ.size() == 0) begin
                    chk("unexpected_request", 32'd1, 32'd0);
                end else begin
                    reqExp_t r;
                    r = reqQ.pop_front();
                    chk("dmem_addr", bus.dmem_addr, r.addr);
                    chk("dmem_be", {28'd0, bus.dmem_be}, {28'd0, r.be});
                    chk("dmem_we", {31'd0, bus.dmem_we}, {31'd0, r.we});
                    if (r.chkWdata) chk("dmem_wdata", bus.dmem_wdata, r.wdata);
                end
            end
            if (done) begin
                if (respQ.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    respExp_t e;
                    e = respQ.pop_front();
                    if (e.chkRdata) chk("rdata_out", rdata_out, e.rdata);
                    chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                    chk("stall_cycles", stallCnt, e.stallCycles);
                end
                stallCnt = 0;
            end
        end
    end

    // gntWait < 0: memory never grants (timeout or trapped access).
    task automatic doTxn(input logic ld, input logic st, input logic [2:0] ls, input logic [1:0] ss,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int gntWait, input int rvWait,
                         input logic [31:0] expAddr, input logic [3:0] expBe, input logic [31:0] expWd,
                         input logic [31:0] expRd, input logic chkRd, input logic expErr, input int expStall);
        bit seen = 0;
        if (gntWait >= 0)
            reqQ.push_back('{addr: expAddr, be: expBe, we: st & ~ld, wdata: expWd, chkWdata: st & ~ld});
        respQ.push_back('{rdata: expRd, chkRdata: chkRd, err: expErr, stallCycles: expStall});
        @(posedge clk); #1;
        load = ld; store = st; load_src = ls; store_src = ss; addr = a; wdata = wd;
        @(posedge clk); #1;
        load = 1'b0; store = 1'b0;
        if (gntWait >= 0) begin
            repeat (gntWait) begin @(posedge clk); #1; end
            bus.dmem_gnt = 1'b1;
            if (ld && rvWait == 0) begin bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd; end
            @(posedge clk); #1;
            bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
            if (ld && rvWait > 0) begin
                repeat (rvWait - 1) begin @(posedge clk); #1; end
                bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rd;
                @(posedge clk); #1;
                bus.dmem_rvalid = 1'b0;
            end
        end
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
        chk("reset_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("reset_rdata", rdata_out, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //     ld st  ls      ss     addr         wdata        rdata        gW rW  expAddr      be       expWd        expRd        cR e  stall
        doTxn(0, 1, 3'b000, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0, 2);
        doTxn(0, 1, 3'b000, 2'b10, 32'h103, 32'h000000A5, 32'h0,        0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0,        0, 0, 2);
        doTxn(1, 0, 3'b010, 2'b00, 32'h102, 32'h0,        32'h11803344, 0, 3, 32'h100, 4'b1111, 32'h0,        32'hFFFFFF80, 1, 0, 5);
        doTxn(1, 0, 3'b100, 2'b00, 32'h102, 32'h0,        32'h11803344, 0, 3, 32'h100, 4'b1111, 32'h0,        32'h00000080, 1, 0, 5);
        doTxn(1, 0, 3'b001, 2'b00, 32'h102, 32'h0,        32'h9ABC0000, 0, 0, 32'h100, 4'b1111, 32'h0,        32'hFFFF9ABC, 1, 0, 2);
        doTxn(0, 1, 3'b000, 2'b01, 32'h102, 32'h1234BEEF, 32'h0,        1, 0, 32'h100, 4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 3);
        doTxn(1, 0, 3'b011, 2'b00, 32'h100, 32'h0,        32'h1234F00D, 2, 1, 32'h100, 4'b1111, 32'h0,        32'h0000F00D, 1, 0, 5);
        doTxn(1, 1, 3'b000, 2'b00, 32'h104, 32'h55555555, 32'hCAFEF00D, 0, 0, 32'h104, 4'b1111, 32'h0,        32'hCAFEF00D, 1, 0, 2);
        doTxn(1, 0, 3'b111, 2'b00, 32'h108, 32'h0,        32'h87654321, 0, 0, 32'h108, 4'b1111, 32'h0,        32'h87654321, 1, 0, 2);
`ifdef MISALIGN_TRAP_EN
        doTxn(1, 0, 3'b000, 2'b00, 32'h101, 32'h0,        32'h11223344, -1, 0, 32'h0,  4'b0000, 32'h0,        32'h0,        1, 1, 1);
`else
        doTxn(1, 0, 3'b000, 2'b00, 32'h101, 32'h0,        32'h11223344, 0, 0, 32'h100, 4'b1111, 32'h0,        32'h00112233, 1, 0, 2);
`endif
        doTxn(0, 1, 3'b000, 2'b00, 32'h200, 32'h12345678, 32'h0,       -1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1, 256);
        chk("stall_released", {31'd0, stall}, 32'd0);

        // Reset while REQ: request must drop without a clock edge.
        doTxn(1, 0, 3'b000, 2'b00, 32'h10C, 32'h0,        32'h0BADCAFE, 0, 0, 32'h10C, 4'b1111, 32'h0,        32'h0BADCAFE, 1, 0, 2);
        @(posedge clk); #1;
        load = 1'b1; load_src = 3'b000; addr = 32'h300;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        chk("req_in_REQ", {31'd0, bus.dmem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_req_drop", {31'd0, bus.dmem_req}, 32'd0);
        chk("reset_stall_REQ", {31'd0, stall}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        // Reset while WAIT, then a late rvalid in IDLE must be ignored.
        reqQ.push_back('{addr: 32'h304, be: 4'b1111, we: 1'b0, wdata: 32'h0, chkWdata: 1'b0});
        @(posedge clk); #1;
        load = 1'b1; load_src = 3'b000; addr = 32'h304;
        @(posedge clk); #1;
        load = 1'b0; bus.dmem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.dmem_gnt = 1'b0;
        @(negedge clk);
        chk("stall_in_WAIT", {31'd0, stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("reset_stall_WAIT", {31'd0, stall}, 32'd0);
        chk("reset_req_WAIT", {31'd0, bus.dmem_req}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1 bus.dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_done", {31'd0, done}, 32'd0);
        chk("late_rvalid_rdata", rdata_out, 32'd0);
        chk("late_rvalid_req", {31'd0, bus.dmem_req}, 32'd0);

        repeat (2) @(posedge clk);
        chk("req_queue_empty", reqQ.size(), 32'd0);
        chk("resp_queue_empty", respQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
